fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
Iterative signed fixed-point divider, the inverse companion of fixed_point_multiplier, for the FFT/fingerprint datapath (normalisation and magnitude ratios). It uses the same enable/done handshake and the same symmetric saturation as the multiplier. It computes quotient = A / B over 16-bit two's-complement Q-format operands with independent binary-point positions. Restoring division produces one quotient bit per clock, so area stays small at the cost of fixed multi-cycle latency.

Parameters:
WIDTH, 16, operand and quotient width (sign included)
EXP_WIDTH_A, 5, fractional bits of A (value = A * 2^-EXP_WIDTH_A)
EXP_WIDTH_B, 5, fractional bits of B
EXP_WIDTH_QUOTIENT, 5, fractional bits of quotient
(derived) SHIFT = EXP_WIDTH_QUOTIENT - EXP_WIDTH_A + EXP_WIDTH_B. It must be >= 0; otherwise fail elaboration.
(derived) DIV_BITS = WIDTH + SHIFT, the number of iteration cycles (21 at defaults).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  start pulse, sampled only in IDLE
A  in  WIDTH  signed dividend
B  in  WIDTH  signed divisor
quotient  out  WIDTH  signed result, held until the next result
done  out  1  one-cycle pulse when quotient is valid
busy  out  1  high from the accepting edge until done is deasserted
overflow  out  1  set with done when the result saturated; held with quotient
div_by_zero  out  1  set with done when B == 0; held with quotient

Behaviour:
- Reset (synchronous): state=IDLE; quotient=0; done=0; busy=0; overflow=0; div_by_zero=0; internal registers cleared. Reset aborts any division in progress, and no done is produced for it.
- State machine IDLE -> DIVIDE -> FINISH -> IDLE.
- IDLE, on an edge with enable=1:
  - Latch sign = A[msb] ^ B[msb], zero flag = (B == 0), |A| and |B| as WIDTH+1-bit unsigned values (0x8000 gives 32768 with no wrap).
  - dividend = |A| << SHIFT; remainder=0; counter=DIV_BITS; busy=1; go to DIVIDE.
- DIVIDE, each cycle (MSB first):
  - remainder = {remainder, next dividend bit}.
  - If remainder >= |B|, subtract |B| and shift in quotient bit 1; otherwise shift in 0.
  - Decrement counter; at zero go to FINISH.
- FINISH, one cycle:
  - B == 0: result = +0x7FFF if A >= 0, else 0x8001; div_by_zero=1; overflow=0.
  - Else if raw magnitude > 0x7FFF: magnitude = 0x7FFF; overflow=1.
  - Apply sign: negate if sign=1 and magnitude != 0. Saturation is symmetric, so the negative limit is 0x8001 and 0x8000 is never produced.
  - Register quotient and flags; done=1; then go to IDLE. busy drops in the same cycle done drops.
- Latency: enable sampled at edge k -> done=1 and quotient valid after edge k+DIV_BITS+1 (22 clocks at defaults).
- Throughput: one division per DIV_BITS+2 cycles. A new enable is accepted on the cycle after done.
- Rounding: truncation toward zero of the magnitude, so -1/3 and 1/3 differ only in sign.
- enable while busy is ignored: no restart and no queueing. Operands are latched at accept, so A and B may change freely afterwards.
- enable held high continuously: a new division starts on each return to IDLE.
- 0 / nonzero gives quotient 0 with both flags 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, DIVIDE, FINISH);
  - the saturation constants (POS_MAX = 0x7FFF, NEG_MAX = 0x8001), shared with fixed_point_multiplier;
  - a to_magnitude / apply_sign helper pair.
- One natural sub-module: div_restoring_step. It is combinational: (remainder, divisor, next bit) -> (new remainder, quotient bit). The top holds the FSM, counter, and sign/saturation logic.

Test Plan:
- All cases use Q10.5 defaults.
- A=0x5078 (643.75), B=0x0050 (2.5), enable for 1 cycle -> quotient=0x2030 (257.5), done exactly 22 clocks after the accepting edge, flags 0.
- A=0xEFCC (-129.625), B=0x0088 (4.25) -> 0xFC30 (-30.5). Repeat with B=0xFF78 (-4.25) -> 0x03D0 (+30.5).
- A=0x7D00 (1000), B=0x0010 (0.5) -> 0x7FFF, overflow=1. A=0x8300 (-1000), same B -> 0x8001, overflow=1.
- A=0xF100 (-120), B=0 -> 0x8001, div_by_zero=1. A=0x0020, B=0 -> 0x7FFF, div_by_zero=1.
- A=0x0020 (1), B=0x0060 (3) -> 0x000A (truncated 0.3125). A=0xFFE0 (-1), B=0x0060 -> 0xFFF6.
- Control: enable re-pulsed mid-DIVIDE with new operands -> ignored, first result unchanged. Reset asserted mid-DIVIDE -> next cycle all outputs 0, no done. A fresh enable then completes normally.

Source files
------------

// File: rtl/fixed_point_divider_pkg.sv
// Shared definitions for the fixed-point divider: FSM encoding, symmetric
// saturation limits and sign/magnitude helpers common with the multiplier.
package fixed_point_divider_pkg;

  localparam int Q_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  // Symmetric limits: the most negative code 0x8000 is never produced.
  localparam logic [Q_W-1:0] POS_MAX = 16'h7FFF;
  localparam logic [Q_W-1:0] NEG_MAX = 16'h8001;

  // One extra bit so that 0x8000 maps to 32768 without wrapping.
  function automatic logic [Q_W:0] to_magnitude(input logic [Q_W-1:0] v);
    logic [Q_W:0] ext;
    ext = {v[Q_W-1], v};
    return v[Q_W-1] ? (~ext + (Q_W+1)'(1)) : ext;
  endfunction

  function automatic logic [Q_W-1:0] apply_sign(input logic [Q_W-1:0] mag,
                                                input logic           neg);
    return (neg && (mag != '0)) ? (~mag + Q_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/fixed_point_divider_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module div_restoring_step #(
  parameter int RW = 17
) (
  input  logic [RW-1:0] rem_i,
  input  logic [RW-1:0] div_i,
  input  logic          bit_i,
  output logic [RW-1:0] rem_o,
  output logic          q_o
);

  logic [RW:0] trial;

  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, div_i});
  // The remainder stays below the divisor, so the difference fits in RW bits.
  assign rem_o = q_o ? RW'(trial - {1'b0, div_i}) : trial[RW-1:0];

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative signed Q-format divider, one quotient bit per clock, with
// enable/done handshake and symmetric saturation.
//
// Handshake: enable is sampled only while IDLE (busy low, or the cycle done is
// high); busy is high from the accepting edge until done drops; done is a
// one-cycle pulse and quotient/overflow/div_by_zero hold until the next done.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
#(
  parameter int WIDTH              = 16,
  parameter int EXP_WIDTH_A        = 5,
  parameter int EXP_WIDTH_B        = 5,
  parameter int EXP_WIDTH_QUOTIENT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero,
  output state_e           state_o
);

  localparam int SHIFT    = EXP_WIDTH_QUOTIENT - EXP_WIDTH_A + EXP_WIDTH_B;
  localparam int DIV_BITS = WIDTH + SHIFT;
  localparam int CW       = $clog2(DIV_BITS + 1);

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("fixed_point_divider: negative quotient shift is not supported");
    end
    if (WIDTH != Q_W) begin : g_bad_width
      $error("fixed_point_divider: WIDTH must match the shared package width");
    end
  endgenerate

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                sign_q;
  logic                zero_q;
  logic                a_neg_q;
  logic [WIDTH:0]      dvs_q;
  logic [DIV_BITS-1:0] dvd_q;
  logic [WIDTH:0]      rem_q;
  logic [DIV_BITS-1:0] quo_q;
  logic [WIDTH-1:0]    quotient_q;
  logic                done_q;
  logic                busy_q;
  logic                overflow_q;
  logic                dbz_q;

  logic [WIDTH:0]      rem_d;
  logic                qbit_d;
  logic                sat_d;
  logic [WIDTH-1:0]    mag_d;

  div_restoring_step #(.RW(WIDTH + 1)) u_step (
    .rem_i (rem_q),
    .div_i (dvs_q),
    .bit_i (dvd_q[DIV_BITS-1]),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  // Any raw quotient bit at or above the sign position means |q| > POS_MAX.
  assign sat_d = |quo_q[DIV_BITS-1:WIDTH-1];
  assign mag_d = sat_d ? POS_MAX : {1'b0, quo_q[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      quotient_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= enable;
          if (enable) begin
            sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            zero_q  <= (B == '0);
            a_neg_q <= A[WIDTH-1];
            dvs_q   <= to_magnitude(B);
            dvd_q   <= DIV_BITS'(to_magnitude(A)) << SHIFT;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= CW'(DIV_BITS);
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[DIV_BITS-2:0], qbit_d};
          dvd_q <= {dvd_q[DIV_BITS-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (zero_q) begin
            quotient_q <= a_neg_q ? NEG_MAX : POS_MAX;
            overflow_q <= 1'b0;
          end else begin
            quotient_q <= apply_sign(mag_d, sign_q);
            overflow_q <= sat_d;
          end
          dbz_q   <= zero_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed Q10.5 vectors, control
// corner cases and random divisions compared against an arithmetic model.
module tb_fixed_point_divider;
  import fixed_point_divider_pkg::*;

  localparam int W       = 16;
  localparam int EA      = 5;
  localparam int EB      = 5;
  localparam int EQ      = 5;
  localparam int SH      = EQ - EA + EB;
  localparam int LATENCY = W + SH + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] quotient;
  logic         done;
  logic         busy;
  logic         overflow;
  logic         div_by_zero;
  state_e       state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected {quotient, overflow, div_by_zero} and the accepting cycle.
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  fixed_point_divider #(
    .WIDTH              (W),
    .EXP_WIDTH_A        (EA),
    .EXP_WIDTH_B        (EB),
    .EXP_WIDTH_QUOTIENT (EQ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .A           (A),
    .B           (B),
    .quotient    (quotient),
    .done        (done),
    .busy        (busy),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, num, den, mag;
    logic   ovf;
    logic [W-1:0] q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      return {(sa < 0) ? 16'h8001 : 16'h7FFF, 1'b0, 1'b1};
    end
    num = ((sa < 0) ? -sa : sa) * (longint'(1) << SH);
    den = (sb < 0) ? -sb : sb;
    mag = num / den;
    ovf = (mag > 32767);
    if (ovf) mag = 32767;
    if ((sa < 0) != (sb < 0)) mag = -mag;
    q = W'(mag);
    return {q, ovf, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          logic [W+1:0] e;
          int           acc;
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("result", 32'({quotient, overflow, div_by_zero}), 32'(e));
          check("latency", 32'(cyc - acc), 32'(LATENCY));
          check("busy_at_done", 32'(busy), 32'd1);
        end
      end else if (acc_q.size() > 0 && cyc >= acc_q[0]) begin
        check("busy_during_divide", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!(busy == 1'b0 || done == 1'b1)) begin
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=busy required=idle at cycle %0d", cyc);
        return;
      end
      @(negedge clk);
    end
    enable = 1'b1;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b));
    acc_q.push_back(cyc);
    @(negedge clk);
    enable = 1'b0;
    A      = W'($urandom);
    B      = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=%0d_pending required=0", exp_q.size());
        exp_q.delete();
        acc_q.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_quotient"}, 32'(quotient), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
    check({name, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
  endtask

  // ---------------- directed table ----------------
  localparam int ND = 10;
  logic [W-1:0] dir_a   [ND] = '{16'h5078, 16'hEFCC, 16'hEFCC, 16'h7D00, 16'h8300,
                                 16'hF100, 16'h0020, 16'h0020, 16'hFFE0, 16'h0000};
  logic [W-1:0] dir_b   [ND] = '{16'h0050, 16'h0088, 16'hFF78, 16'h0010, 16'h0010,
                                 16'h0000, 16'h0000, 16'h0060, 16'h0060, 16'h0123};
  logic [W+1:0] dir_exp [ND] = '{{16'h2030, 2'b00}, {16'hFC30, 2'b00}, {16'h03D0, 2'b00},
                                 {16'h7FFF, 2'b10}, {16'h8001, 2'b10}, {16'h8001, 2'b01},
                                 {16'h7FFF, 2'b01}, {16'h000A, 2'b00}, {16'hFFF6, 2'b00},
                                 {16'h0000, 2'b00}};

  // ---------------- main sequence ----------------
  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    A      = '0;
    B      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(state_o), 32'(S_IDLE));
    reset = 1'b0;

    // Pin the model to hand-computed values, then run the vectors.
    for (int i = 0; i < ND; i++) begin
      check("model_pin", 32'(model(dir_a[i], dir_b[i])), 32'(dir_exp[i]));
    end
    for (int i = 0; i < ND; i++) begin
      run_div(dir_a[i], dir_b[i]);
      wait_idle();
    end

    // enable re-pulsed mid-divide with new operands must be ignored.
    run_div(16'h5078, 16'h0050);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    A      = 16'h1234;
    B      = 16'h0001;
    @(negedge clk);
    enable = 1'b0;
    wait_idle();

    // Reset mid-divide aborts with no done.
    run_div(16'h0020, 16'h0060);
    repeat (6) @(negedge clk);
    exp_q.delete();
    acc_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    run_div(16'hEFCC, 16'h0088);
    wait_idle();

    // Back-to-back: each new enable lands on the done cycle.
    run_div(16'h5078, 16'h0050);
    run_div(16'hFFE0, 16'h0060);
    run_div(16'h7D00, 16'h0010);
    wait_idle();

    // Random operands, mixing zero, tiny and arbitrary divisors.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      int mode;
      ra   = W'($urandom);
      mode = $urandom_range(0, 4);
      case (mode)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 64));
        2:       rb = W'(-$urandom_range(1, 64));
        default: rb = W'($urandom);
      endcase
      if (mode == 3) ra = W'($urandom_range(0, 255));
      run_div(ra, rb);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    run_div(16'h8000, 16'h0001);
    run_div(16'h8000, 16'hFFFF);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
